// File: rtl/tts_pkg.sv
// Shared types and defaults for the truth-table sweep engine.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned TTS_DEF_N_IN = 3;
  localparam int unsigned TTS_DEF_HOLD = 1;

  // Hold-counter width: clog2(HOLD), never below one bit.
  function automatic int unsigned tts_cnt_w(input int unsigned hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/tts_hold_cnt.sv
// Counts 0..HOLD-1 while enabled; last is registered and marks the HOLD-1 cycle.
module tts_hold_cnt
  import tts_pkg::*;
#(
  parameter int unsigned HOLD = TTS_DEF_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned CW = tts_cnt_w(HOLD);
  localparam logic        ONE_CYCLE = (HOLD == 1);

  logic [CW-1:0] cnt;

  // last is precomputed so it is high exactly while cnt == HOLD-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      last <= ONE_CYCLE;
    end else if (en) begin
      if (last) begin
        cnt  <= '0;
        last <= ONE_CYCLE;
      end else begin
        cnt  <= cnt + CW'(1);
        last <= (cnt == CW'(HOLD - 2));
      end
    end
  end

endmodule

// File: rtl/truth_table_seq.sv
// Sweeps every minterm onto vec, captures s_in into tbl, pulses done.
// Optional checker against exp_tbl is compiled in with `define TTS_CHECK_EN.
module truth_table_seq
  import tts_pkg::*;
#(
  parameter int unsigned N_IN = TTS_DEF_N_IN,
  parameter int unsigned HOLD = TTS_DEF_HOLD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_in,
  input  logic [(2**N_IN)-1:0]  exp_tbl,
  output logic [N_IN-1:0]       vec,
  output logic [N_IN-1:0]       m,
  output logic                  busy,
  output logic                  done,
  output logic [(2**N_IN)-1:0]  tbl,
  output logic                  mismatch
);

  localparam int unsigned M_CNT = 2**N_IN;
  localparam logic [N_IN-1:0] M_MAX = N_IN'(M_CNT - 1);

  state_t state;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_last;
  logic   mm_next;

  assign cnt_clr = (state == IDLE) && start;
  assign cnt_en  = (state == RUN);
  assign vec     = m;

  tts_hold_cnt #(.HOLD(HOLD)) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

`ifdef TTS_CHECK_EN
  logic [M_CNT-1:0] tbl_final;

  // Compare against the table with the last sample already merged in
  always_comb begin
    tbl_final    = tbl;
    tbl_final[m] = s_in;
    mm_next      = (tbl_final != exp_tbl);
  end
`else
  logic unused_exp_tbl;

  assign unused_exp_tbl = ^exp_tbl;
  assign mm_next        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m        <= '0;
      tbl      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            m        <= '0;
            tbl      <= '0;
            mismatch <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_last) begin
            tbl[m] <= s_in;
            // Last minterm ends the sweep instead of wrapping m
            if (m == M_MAX) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              mismatch <= mm_next;
            end else begin
              m <= m + N_IN'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_seq.sv
// Scoreboard bench: two sweepers (HOLD=1 and HOLD=3) driven against a table-lookup unit.
module tb_truth_table_seq;
  import tts_pkg::*;

  localparam int unsigned NM = 8;

  typedef struct {
    int unsigned k;
    logic [7:0]  tbl;
    logic        mm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] st = 2'b00;
  logic [7:0] exp_tbl = 8'h00;
  logic [7:0] unit_tbl = 8'h00;

  logic [1:0] s_in;
  logic [1:0] busy_w;
  logic [1:0] done_w;
  logic [1:0] mm_w;
  logic [1:0][2:0] vec_w;
  logic [1:0][2:0] m_w;
  logic [1:0][7:0] tbl_w;

  exp_t        sbq[2][$];
  logic [7:0]  last_tbl[2];
  logic        last_mm[2];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The unit under sweep: its response to each input combination is a lookup
  assign s_in[0] = unit_tbl[vec_w[0]];
  assign s_in[1] = unit_tbl[vec_w[1]];

  truth_table_seq #(.N_IN(3), .HOLD(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .s_in(s_in[0]), .exp_tbl(exp_tbl),
    .vec(vec_w[0]), .m(m_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .tbl(tbl_w[0]), .mismatch(mm_w[0]));

  truth_table_seq #(.N_IN(3), .HOLD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .s_in(s_in[1]), .exp_tbl(exp_tbl),
    .vec(vec_w[1]), .m(m_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .tbl(tbl_w[1]), .mismatch(mm_w[1]));

  function automatic int unsigned hold_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic exp_mm(input logic [7:0] t, input logic [7:0] e);
`ifdef TTS_CHECK_EN
    return t != e;
`else
    return 1'b0;
`endif
  endfunction

  // OR/NOR unit: c selects NOR, otherwise OR of a and b
  function automatic logic [7:0] or_nor_table();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      logic a, b, c;
      a = ((i >> 2) & 1) != 0;
      b = ((i >> 1) & 1) != 0;
      c = (i & 1) != 0;
      r[i] = c ? !(a || b) : (a || b);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d @cyc %0d: got %0h want %0h", nm, i, cyc, act, want);
    end
  endtask

  // Monitor: follows the head expectation cycle by cycle and pops on done
  always @(negedge clk) begin
    int unsigned t;
    int unsigned h;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        h = hold_of(i);
        if (sbq[i].size() > 0 && cyc >= sbq[i][0].k) begin
          t = cyc - sbq[i][0].k;
          if (t < NM * h) begin
            chk("busy", i, 32'(busy_w[i]), 32'd1);
            chk("m", i, 32'(m_w[i]), t / h);
            chk("vec", i, 32'(vec_w[i]), t / h);
            chk("early_done", i, 32'(done_w[i]), 32'd0);
          end else begin
            chk("done", i, 32'(done_w[i]), 32'd1);
            chk("done_busy", i, 32'(busy_w[i]), 32'd0);
            chk("tbl", i, 32'(tbl_w[i]), 32'(sbq[i][0].tbl));
            chk("mismatch", i, 32'(mm_w[i]), 32'(sbq[i][0].mm));
            last_tbl[i] = sbq[i][0].tbl;
            last_mm[i]  = sbq[i][0].mm;
            void'(sbq[i].pop_front());
          end
        end else begin
          chk("idle_busy", i, 32'(busy_w[i]), 32'd0);
          chk("idle_done", i, 32'(done_w[i]), 32'd0);
          chk("idle_tbl", i, 32'(tbl_w[i]), 32'(last_tbl[i]));
          chk("idle_mm", i, 32'(mm_w[i]), 32'(last_mm[i]));
        end
      end
    end
  end

  // Hold start for nedges edges; an idle sweeper accepts every 8*HOLD+2 edges
  task automatic sweep_start(input int i, input int nedges, input logic [7:0] want);
    exp_t e;
    @(negedge clk);
    st[i] = 1'b1;
    for (int n = 0; n < nedges; n++) begin
      @(posedge clk);
      #1;
      if (n % int'(NM * hold_of(i) + 2) == 0) begin
        e.k   = cyc;
        e.tbl = want;
        e.mm  = exp_mm(want, exp_tbl);
        sbq[i].push_back(e);
      end
    end
    st[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (sbq[i].size() > 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq[i].size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d: %0d sweeps still pending", i, sbq[i].size());
      sbq[i].delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input int i);
    chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
    chk("rst_done", i, 32'(done_w[i]), 32'd0);
    chk("rst_m", i, 32'(m_w[i]), 32'd0);
    chk("rst_vec", i, 32'(vec_w[i]), 32'd0);
    chk("rst_tbl", i, 32'(tbl_w[i]), 32'd0);
    chk("rst_mm", i, 32'(mm_w[i]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] golden;
    exp_t e;
    int unsigned k;
    golden = or_nor_table();
    for (int i = 0; i < 2; i++) begin
      last_tbl[i] = 8'h00;
      last_mm[i]  = 1'b0;
    end
    unit_tbl = golden;
    repeat (2) @(negedge clk);
    check_zero(0);
    check_zero(1);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden sweep and checker hit on both hold settings
    exp_tbl = 8'h56;
    for (int i = 0; i < 2; i++) begin
      sweep_start(i, 1, 8'h56);
      drain(i);
    end
    exp_tbl = 8'h57;
    for (int i = 0; i < 2; i++) begin
      sweep_start(i, 1, 8'h56);
      drain(i);
    end
    exp_tbl = 8'h56;

    // Start while busy at minterm 4 must be ignored
    sweep_start(0, 1, 8'h56);
    repeat (5) @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    drain(0);

    // Reset at minterm 5: outputs clear at once, no done
    sweep_start(0, 1, 8'h56);
    k = sbq[0][0].k;
    repeat (6) @(negedge clk);
    chk("pre_rst_m", 0, 32'(m_w[0]), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check_zero(0);
    sbq[0].delete();
    sbq[1].delete();
    last_tbl[0] = 8'h00;
    last_mm[0]  = 1'b0;
    last_tbl[1] = 8'h00;
    last_mm[1]  = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gap", 0, cyc - k, 32'd9);
    sweep_start(0, 1, 8'h56);
    drain(0);

    // Continuous start: back-to-back sweeps with one idle cycle between
    sweep_start(0, 30, 8'h56);
    drain(0);
    sweep_start(1, 30, 8'h56);
    drain(1);

    // Random unit tables, expected tables and start lengths
    for (int r = 0; r < 24; r++) begin
      int i;
      i = int'($urandom_range(0, 1));
      unit_tbl = 8'($urandom);
      exp_tbl  = ($urandom_range(0, 1) == 1) ? unit_tbl : 8'($urandom);
      sweep_start(i, int'($urandom_range(1, 24)), unit_tbl);
      drain(i);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_seq.md
# truth_table_seq

Sequential sweep engine that sits directly upstream of the selectable OR/NOR unit and also consumes its output. On a start pulse it drives every input combination (minterm) onto the unit's inputs in ascending order, holds each for a programmable settle time, and samples the unit's result. It assembles the results into a truth-table word and signals completion with a one-cycle done pulse. This replaces hand-written stimulus sequences and gives the unit a clocked, self-checking wrapper.

## Interface
- `N_IN`, default 3: number of unit inputs swept; minterm count is 2**N_IN.
- `HOLD`, default 1: cycles each minterm is held before sampling; legal range ≥ 1.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `start`  input  1  begin sweep; sampled only in IDLE.
- `s_in`  input  1  result from the unit, combinational response to `vec`.
- `exp_tbl`  input  2**N_IN  expected truth table; used only when checking is compiled in.
- `vec`  output  N_IN  unit inputs. MSB = a, LSB = c (selector); `vec` equals the current minterm index.
- `m`  output  N_IN  current minterm index.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle pulse in DONE.
- `tbl`  output  2**N_IN  captured table; `tbl[i]` = `s_in` sampled for minterm i.
- `mismatch`  output  1  `tbl` ≠ `exp_tbl`; valid from `done`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `start` = 1 → RUN.
  - On entry to RUN: `m` = 0, hold counter = 0, `tbl` cleared to 0, `mismatch` cleared.
- **RUN**
  - `vec` = `m`. The hold counter counts 0 … HOLD-1.
  - At the edge where the hold counter = HOLD-1:
    - `tbl[m]` ← `s_in`.
    - If `m` = 2**N_IN-1 → DONE. Otherwise `m` ← `m`+1 and the hold counter ← 0.
  - `m` does not wrap during RUN; the last-minterm compare selects DONE instead.
- **DONE**
  - `done` = 1 for exactly one cycle, then → IDLE.
  - `mismatch` is registered on entry to DONE.
- `start` in RUN or DONE is ignored. A new sweep needs `start` while in IDLE.
- `start` held high continuously produces back-to-back sweeps, with one IDLE cycle between them.
- `tbl` and `mismatch` hold their values in IDLE until the next accepted `start`.
- In IDLE, `vec` and `m` hold their last values.

## Timing
- Reset values, applied asynchronously: state = IDLE; `vec`, `m`, `tbl`, hold counter, `busy`, `done`, `mismatch` = 0.
- Sequence for `start` sampled at edge k:
  - `busy` rises after edge k.
  - Minterm i is sampled at edge k + (i+1)·HOLD.
  - `done` is high in the cycle after edge k + 2**N_IN·HOLD.
  - State returns to IDLE one edge later.
- Sweep length: 2**N_IN·HOLD cycles in RUN. With the defaults this is 8 cycles.
- `s_in` must settle within HOLD cycles of a `vec` change. The unit is purely combinational, so HOLD = 1 suffices.
- Reset mid-sweep: immediate return to IDLE. The partial `tbl` is discarded (zeroed), and `done` never pulses for that sweep.

## Configuration
- Macro: `TTS_CHECK_EN`.
- **Defined:** on entry to DONE, `mismatch` ← (`tbl` with the final sample merged) ≠ `exp_tbl`. The comparison uses the completed table.
- **Undefined:** the `exp_tbl` port is present but ignored, `mismatch` is tied 0, and no comparator is synthesized.

## Structure
- Package `tts_pkg`:
  - `state_t` enum: IDLE, RUN, DONE.
  - Constant `TTS_DEF_N_IN` = 3.
  - Constant `TTS_DEF_HOLD` = 1.
- Sub-module `tts_hold_cnt`:
  - Parameterised HOLD-cycle counter with `clr`, `en` and a `last` flag.
  - Width is clog2(HOLD), minimum 1.
- The OR/NOR unit is instantiated outside this block, by the bench or the parent, and connected via `vec` / `s_in`.

## Test plan
- **Golden sweep** (defaults, connected to the OR/NOR unit, `exp_tbl` = 8'h56): pulse `start` → `vec` steps 0…7, one per cycle; `done` pulses once; `tbl` = 8'h56; `mismatch` = 0.
- **Checker hit** (`TTS_CHECK_EN` defined, `exp_tbl` = 8'h57): same sweep → `tbl` = 8'h56, `mismatch` = 1. With the macro undefined → `mismatch` = 0.
- **HOLD** = 3: `start` → `busy` high for 24 cycles; `m` changes every 3 cycles; `done` occurs 24 edges after the start edge; `tbl` = 8'h56.
- **Start ignored:** pulse `start` at minterm 4 → sweep unaffected, exactly one `done`, `tbl` = 8'h56.
- **Reset mid-sweep:** drop `rst_n` at minterm 5 → all outputs 0 immediately, no `done`. A new `start` then yields `tbl` = 8'h56.
- **Continuous start:** `start` held high for 30 cycles → `done` pulses spaced 10 cycles apart (8 RUN + DONE + IDLE); each sweep gives `tbl` = 8'h56.
